// File: rtl/reg_wr_post_fifo_if.sv
// Register write channel: one addressed, bit-masked write per cycle with write high.
interface reg_wrchan_if #(
  parameter int unsigned K_AWIDTH = 16,
  parameter int unsigned K_DWIDTH = 8
);
  logic [K_AWIDTH-1:0] addr;
  logic [K_DWIDTH-1:0] data;
  logic [K_DWIDTH-1:0] bmask;
  logic                write;

  modport master (output addr, output data, output bmask, output write);
  modport slave  (input addr, input data, input bmask, input write);
endinterface

// File: rtl/reg_wr_post_fifo.sv
// Posted-write FIFO in front of the register bank: queues bus writes, optionally merges
// same-address writes into the tail entry, and replays them as single-cycle write pulses.
module reg_wr_post_fifo #(
  parameter int unsigned K_DWIDTH = 8,
  parameter int unsigned K_AWIDTH = 16,
  parameter int unsigned K_DEPTH  = 4,
  parameter int unsigned K_GAP    = 0,
  parameter int unsigned K_MERGE  = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [K_AWIDTH-1:0]       i_addr,
  input  logic [K_DWIDTH-1:0]       i_data,
  input  logic [K_DWIDTH-1:0]       i_bmask,
  input  logic                      i_hold,
  reg_wrchan_if.master              o_wrchan,
  output logic [$clog2(K_DEPTH):0]  o_count,
  output logic                      o_busy
);

  localparam int unsigned PW = $clog2(K_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = (K_GAP > 0) ? $clog2(K_GAP + 1) : 1;

  logic [K_AWIDTH-1:0] mem_addr  [K_DEPTH];
  logic [K_DWIDTH-1:0] mem_data  [K_DEPTH];
  logic [K_DWIDTH-1:0] mem_bmask [K_DEPTH];

  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       tail_ptr;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic [GW-1:0]       gap_cnt;

  logic                accept;
  logic                pop;
  logic                tail_pop;
  logic                merge;
  logic                push;
  logic                busy_nxt;
  logic [K_DWIDTH-1:0] merge_data;
  logic [K_DWIDTH-1:0] merge_bmask;

  logic [K_AWIDTH-1:0] wr_addr_q;
  logic [K_DWIDTH-1:0] wr_data_q;
  logic [K_DWIDTH-1:0] wr_bmask_q;
  logic                wr_write_q;
  logic                busy_q;

  // Handshake, pop eligibility and merge/push decision
  always_comb begin
    o_ready     = 1'b0;
    accept      = 1'b0;
    pop         = 1'b0;
    tail_pop    = 1'b0;
    merge       = 1'b0;
    push        = 1'b0;
    count_nxt   = count;
    busy_nxt    = 1'b0;
    tail_ptr    = wr_ptr - PW'(1);
    merge_data  = (mem_data[tail_ptr] & ~i_bmask) | (i_data & i_bmask);
    merge_bmask = mem_bmask[tail_ptr] | i_bmask;

    o_ready  = (count < CW'(K_DEPTH));
    accept   = i_valid && o_ready;
    pop      = (count != '0) && !i_hold && (gap_cnt == '0);
    // Head and tail are the same entry when only one is held; it cannot absorb a merge.
    tail_pop = pop && (count == CW'(1));
    merge    = (K_MERGE != 0) && accept && (i_bmask != '0) && (count != '0) &&
               (i_addr == mem_addr[tail_ptr]) && !tail_pop;
    push     = accept && (i_bmask != '0) && !merge;

    case ({push, pop})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
    busy_nxt = (count_nxt != '0) || pop;
  end

  // Control state and registered write channel
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      gap_cnt    <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_bmask_q <= '0;
      wr_write_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      count      <= count_nxt;
      busy_q     <= busy_nxt;
      wr_write_q <= pop;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr     <= rd_ptr + PW'(1);
        wr_addr_q  <= mem_addr[rd_ptr];
        wr_data_q  <= mem_data[rd_ptr];
        wr_bmask_q <= mem_bmask[rd_ptr];
        gap_cnt    <= GW'(K_GAP);
      end else if (gap_cnt != '0) begin
        gap_cnt <= gap_cnt - GW'(1);
      end
    end
  end

  // Entry storage; stale contents are never read because count gates every access
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr[wr_ptr]  <= i_addr;
      mem_data[wr_ptr]  <= i_data;
      mem_bmask[wr_ptr] <= i_bmask;
    end else if (merge) begin
      mem_data[tail_ptr]  <= merge_data;
      mem_bmask[tail_ptr] <= merge_bmask;
    end
  end

  assign o_wrchan.addr  = wr_addr_q;
  assign o_wrchan.data  = wr_data_q;
  assign o_wrchan.bmask = wr_bmask_q;
  assign o_wrchan.write = wr_write_q;
  assign o_count        = count;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_reg_wr_post_fifo.sv
// Directed bench: dut_a uses K_GAP=0, dut_b uses K_GAP=2; both K_DEPTH=4, K_MERGE=1.
module tb_reg_wr_post_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        va = 1'b0, ha = 1'b0;
  logic [15:0] aa = '0;
  logic [7:0]  da = '0, ma = '0;
  logic        ra, busy_a;
  logic [2:0]  cnt_a;

  logic        vb = 1'b0, hb = 1'b0;
  logic [15:0] ab = '0;
  logic [7:0]  db = '0, mb = '0;
  logic        rb, busy_b;
  logic [2:0]  cnt_b;

  int n_pass = 0;
  int n_total = 0;

  reg_wrchan_if #(.K_AWIDTH(16), .K_DWIDTH(8)) wa ();
  reg_wrchan_if #(.K_AWIDTH(16), .K_DWIDTH(8)) wb ();

  reg_wr_post_fifo #(.K_DWIDTH(8), .K_AWIDTH(16), .K_DEPTH(4), .K_GAP(0), .K_MERGE(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(va), .o_ready(ra), .i_addr(aa), .i_data(da),
    .i_bmask(ma), .i_hold(ha), .o_wrchan(wa), .o_count(cnt_a), .o_busy(busy_a));

  reg_wr_post_fifo #(.K_DWIDTH(8), .K_AWIDTH(16), .K_DEPTH(4), .K_GAP(2), .K_MERGE(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(vb), .o_ready(rb), .i_addr(ab), .i_data(db),
    .i_bmask(mb), .i_hold(hb), .o_wrchan(wb), .o_count(cnt_b), .o_busy(busy_b));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [15:0] a, input logic [7:0] d, input logic [7:0] m);
    va = v; aa = a; da = d; ma = m;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_total++; if (wa.write !== 1'b0) $display("FAIL reset_write got %b exp 0", wa.write); else n_pass++;
    n_total++; if (cnt_a !== 3'd0) $display("FAIL reset_count got %0d exp 0", cnt_a); else n_pass++;
    n_total++; if (ra !== 1'b1) $display("FAIL reset_ready got %b exp 1", ra); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_a); else n_pass++;
    n_total++; if ({wa.addr, wa.data, wa.bmask} !== 32'h0) $display("FAIL reset_fields got %h exp 0", {wa.addr, wa.data, wa.bmask}); else n_pass++;
    n_total++; if (cnt_b !== 3'd0 || wb.write !== 1'b0) $display("FAIL reset_b got cnt=%0d wr=%b exp 0/0", cnt_b, wb.write); else n_pass++;
    #3 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    drive_a(1'b1, 16'h0010, 8'hA5, 8'hFF);
    tick();
    drive_a(1'b0, '0, '0, '0);
    n_total++; if (cnt_a !== 3'd1 || wa.write !== 1'b0) $display("FAIL single_accept got cnt=%0d wr=%b exp 1/0", cnt_a, wa.write); else n_pass++;
    tick();
    n_total++; if (wa.write !== 1'b1) $display("FAIL single_pulse got %b exp 1", wa.write); else n_pass++;
    n_total++; if ({wa.addr, wa.data, wa.bmask} !== 32'h0010_A5FF) $display("FAIL single_fields got %h exp 0010a5ff", {wa.addr, wa.data, wa.bmask}); else n_pass++;
    n_total++; if (busy_a !== 1'b1) $display("FAIL single_busy_hi got %b exp 1", busy_a); else n_pass++;
    tick();
    n_total++; if (wa.write !== 1'b0) $display("FAIL single_end got %b exp 0", wa.write); else n_pass++;
    n_total++; if (busy_a !== 1'b0) $display("FAIL single_busy_lo got %b exp 0", busy_a); else n_pass++;
    n_total++; if (wa.addr !== 16'h0010 || wa.data !== 8'hA5) $display("FAIL single_hold_fields got %h/%h exp 0010/a5", wa.addr, wa.data); else n_pass++;
  endtask

  task automatic test_fill_drain();
    logic [15:0] exp_addr [4];
    logic [7:0]  exp_data [4];
    exp_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    exp_data = '{8'h11, 8'h22, 8'h33, 8'h44};
    ha = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, exp_addr[i], exp_data[i], 8'hFF);
      tick();
    end
    drive_a(1'b0, '0, '0, '0);
    n_total++; if (cnt_a !== 3'd4) $display("FAIL fill_count got %0d exp 4", cnt_a); else n_pass++;
    n_total++; if (ra !== 1'b0) $display("FAIL fill_ready got %b exp 0", ra); else n_pass++;
    ha = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (wa.write !== 1'b1 || wa.addr !== exp_addr[i] || wa.data !== exp_data[i])
        $display("FAIL drain_%0d got wr=%b %h/%h exp 1 %h/%h", i, wa.write, wa.addr, wa.data, exp_addr[i], exp_data[i]);
      else n_pass++;
      n_total++; if (ra !== 1'b1) $display("FAIL drain_ready_%0d got %b exp 1", i, ra); else n_pass++;
    end
    tick();
    n_total++; if (wa.write !== 1'b0 || cnt_a !== 3'd0) $display("FAIL drain_end got wr=%b cnt=%0d exp 0/0", wa.write, cnt_a); else n_pass++;
  endtask

  task automatic test_merge();
    ha = 1'b1;
    drive_a(1'b1, 16'h0020, 8'h0F, 8'h0F);
    tick();
    drive_a(1'b1, 16'h0020, 8'hF0, 8'hF0);
    tick();
    drive_a(1'b0, '0, '0, '0);
    n_total++; if (cnt_a !== 3'd1) $display("FAIL merge_count got %0d exp 1", cnt_a); else n_pass++;
    ha = 1'b0;
    tick();
    n_total++;
    if (wa.write !== 1'b1 || {wa.addr, wa.data, wa.bmask} !== 32'h0020_FFFF)
      $display("FAIL merge_pulse got wr=%b %h exp 1 0020ffff", wa.write, {wa.addr, wa.data, wa.bmask});
    else n_pass++;
    tick();
    n_total++; if (wa.write !== 1'b0 || cnt_a !== 3'd0) $display("FAIL merge_single got wr=%b cnt=%0d exp 0/0", wa.write, cnt_a); else n_pass++;
  endtask

  task automatic test_merge_blocked();
    ha = 1'b1;
    drive_a(1'b1, 16'h0030, 8'h01, 8'h01);
    tick();
    ha = 1'b0;
    drive_a(1'b1, 16'h0030, 8'h02, 8'h02);
    tick();
    drive_a(1'b0, '0, '0, '0);
    n_total++;
    if (wa.write !== 1'b1 || wa.data !== 8'h01 || wa.bmask !== 8'h01 || cnt_a !== 3'd1)
      $display("FAIL blocked_first got wr=%b d=%h m=%h cnt=%0d exp 1 01 01 1", wa.write, wa.data, wa.bmask, cnt_a);
    else n_pass++;
    tick();
    n_total++;
    if (wa.write !== 1'b1 || wa.addr !== 16'h0030 || wa.data !== 8'h02 || wa.bmask !== 8'h02)
      $display("FAIL blocked_second got wr=%b a=%h d=%h m=%h exp 1 0030 02 02", wa.write, wa.addr, wa.data, wa.bmask);
    else n_pass++;
    tick();
    n_total++; if (wa.write !== 1'b0) $display("FAIL blocked_end got %b exp 0", wa.write); else n_pass++;
  endtask

  task automatic test_gap();
    logic [15:0] qa [4];
    logic [7:0]  qm [4];
    logic [15:0] pa [3];
    int          np;
    qa = '{16'h0040, 16'h0041, 16'h0042, 16'h0043};
    qm = '{8'hFF, 8'h00, 8'hFF, 8'hFF};
    pa = '{16'h0040, 16'h0042, 16'h0043};
    np = 0;
    hb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vb = 1'b1; ab = qa[i]; db = 8'h50 + 8'(i); mb = qm[i];
      tick();
    end
    vb = 1'b0; mb = '0;
    n_total++; if (cnt_b !== 3'd3) $display("FAIL gap_zero_drop got %0d exp 3", cnt_b); else n_pass++;
    hb = 1'b0;
    for (int c = 0; c < 10; c++) begin
      logic exp_wr;
      tick();
      exp_wr = (c == 0) || (c == 3) || (c == 6);
      n_total++; if (wb.write !== exp_wr) $display("FAIL gap_wr_c%0d got %b exp %b", c, wb.write, exp_wr); else n_pass++;
      if (exp_wr) begin
        n_total++; if (wb.addr !== pa[np]) $display("FAIL gap_addr_%0d got %h exp %h", np, wb.addr, pa[np]); else n_pass++;
        np++;
      end
    end
  endtask

  task automatic test_reset_mid();
    ha = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 16'h0060 + 16'(i), 8'h70 + 8'(i), 8'hFF);
      tick();
    end
    drive_a(1'b0, '0, '0, '0);
    ha = 1'b0;
    tick();
    n_total++; if (wa.write !== 1'b1 || cnt_a !== 3'd2) $display("FAIL rstmid_pre got wr=%b cnt=%0d exp 1/2", wa.write, cnt_a); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (wa.write !== 1'b0 || cnt_a !== 3'd0 || busy_a !== 1'b0) $display("FAIL rstmid_async got wr=%b cnt=%0d busy=%b exp 0/0/0", wa.write, cnt_a, busy_a); else n_pass++;
    #2 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_total++; if (wa.write !== 1'b0 || cnt_a !== 3'd0) $display("FAIL rstmid_stale_c%0d got wr=%b cnt=%0d exp 0/0", c, wa.write, cnt_a); else n_pass++;
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_single_write();
    test_fill_drain();
    test_merge();
    test_merge_blocked();
    test_gap();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
